// File: rtl/enc8to3_stream.sv
// Sequential 8-to-3 priority encoder: captures a multi-hot request vector and
// streams the index of every set bit, highest first, one per handshake.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no vector held; load with en captures i (zero vector -> none)
// SCAN  | pend holds unsent bits; q shows the highest one while en is high
module enc8to3_stream #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          load,
    input  logic [N-1:0]  i,
    output logic [IW-1:0] q,
    output logic          q_valid,
    input  logic          q_ready,
    output logic          busy,
    output logic          done,
    output logic          none
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  pend_q, pend_d;
    logic          done_q, done_d;
    logic          none_q, none_d;
    logic [IW-1:0] top_idx;
    logic [N-1:0]  pend_clr;
    logic          fire;

    // Ascending scan so the highest set bit is the last assignment to win.
    always_comb begin
        top_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (pend_q[k]) begin
                top_idx = IW'(k);
            end
        end
    end

    assign pend_clr = pend_q & ~(N'(1) << top_idx);
    assign fire     = (state_q == SCAN) && en && q_ready;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        none_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && load) begin
                    if (i != '0) begin
                        pend_d  = i;
                        state_d = SCAN;
                    end else begin
                        none_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (fire) begin
                    pend_d = pend_clr;
                    if (pend_clr == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            done_q  <= 1'b0;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            none_q  <= none_d;
        end
    end

    // q is forced to zero whenever it is not being offered.
    assign q_valid = (state_q == SCAN) && en;
    assign q       = q_valid ? top_idx : '0;
    assign busy    = (state_q == SCAN);
    assign done    = done_q;
    assign none    = none_q;

endmodule

// File: tb/tb_enc8to3_stream.sv
// Bench for enc8to3_stream: directed scenarios plus random traffic, checked
// against a queue-of-indices reference model.
`timescale 1ns/1ps
module tb_enc8to3_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       load;
    logic [7:0] i_vec;
    logic [2:0] q;
    logic       q_valid;
    logic       q_ready;
    logic       busy;
    logic       done;
    logic       none;

    int n_cmp = 0;
    int n_err = 0;

    // Model: indices still to be emitted, in emission order.
    int exp_idx[$];
    bit exp_done = 1'b0;
    bit exp_none = 1'b0;

    always #5 clk = ~clk;

    enc8to3_stream dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .load    (load),
        .i       (i_vec),
        .q       (q),
        .q_valid (q_valid),
        .q_ready (q_ready),
        .busy    (busy),
        .done    (done),
        .none    (none)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input bit en_v);
        bit vld;
        vld = en_v && (exp_idx.size() > 0);
        check("q_valid", int'(q_valid), int'(vld));
        check("q", int'(q), vld ? exp_idx[0] : 0);
        check("busy", int'(busy), int'(exp_idx.size() > 0));
        check("done", int'(done), int'(exp_done));
        check("none", int'(none), int'(exp_none));
    endtask

    // One clock cycle: drive, check pre-edge outputs, advance the model.
    task automatic step(input bit en_v, input bit load_v, input logic [7:0] i_v,
                        input bit rdy_v);
        bit was_busy;
        bit nd;
        bit nn;
        @(negedge clk);
        en      = en_v;
        load    = load_v;
        i_vec   = i_v;
        q_ready = rdy_v;
        #1;
        check_outputs(en_v);
        nd       = 1'b0;
        nn       = 1'b0;
        was_busy = (exp_idx.size() > 0);
        if (en_v && was_busy && rdy_v) begin
            void'(exp_idx.pop_front());
            if (exp_idx.size() == 0) nd = 1'b1;
        end
        if (en_v && load_v && !was_busy) begin
            if (i_v != 8'h00) begin
                for (int b = 7; b >= 0; b--) begin
                    if (i_v[b]) exp_idx.push_back(b);
                end
            end else begin
                nn = 1'b1;
            end
        end
        exp_done = nd;
        exp_none = nn;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic mid_cycle_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_idx.delete();
        exp_done = 1'b0;
        exp_none = 1'b0;
        #1;
        check("rst_q_valid", int'(q_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_q", int'(q), 0);
        check("rst_done", int'(done), 0);
        check("rst_none", int'(none), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        load    = 1'b0;
        i_vec   = 8'h00;
        q_ready = 1'b0;
        #1;
        check_outputs(1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1010_0100 with ready high: 7,5,2 then done.
        step(1, 1, 8'b1010_0100, 1);
        repeat (5) step(1, 0, 8'h00, 1);

        // Zero vector: none pulse only.
        step(1, 1, 8'h00, 1);
        repeat (3) step(1, 0, 8'h00, 1);

        // 0xFF with ready toggling.
        step(1, 1, 8'hFF, 0);
        for (int c = 0; c < 18; c++) step(1, 0, 8'h00, (c % 2) == 0);

        // en gap after q=4 is shown.
        step(1, 1, 8'b0001_1000, 0);
        step(1, 0, 8'h00, 0);
        repeat (3) step(0, 0, 8'h00, 1);
        repeat (4) step(1, 0, 8'h00, 1);

        // Load while busy is ignored.
        step(1, 1, 8'b1000_0001, 1);
        step(1, 1, 8'h10, 1);
        repeat (3) step(1, 0, 8'h00, 1);

        // Load ignored while en is low.
        step(0, 1, 8'h55, 1);
        step(1, 0, 8'h00, 1);

        // Reset mid-SCAN after q=6 accepted, then recover.
        step(1, 1, 8'hF0, 1);
        step(1, 0, 8'h00, 1);
        step(1, 0, 8'h00, 1);
        mid_cycle_reset();
        step(1, 1, 8'h02, 1);
        repeat (3) step(1, 0, 8'h00, 1);

        // Back-to-back load in the done cycle.
        step(1, 1, 8'h01, 1);
        step(1, 0, 8'h00, 1);
        step(1, 1, 8'h0C, 1);
        repeat (4) step(1, 0, 8'h00, 1);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom),
                 ($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
